shared_ram_arbiter: RTL and testbench

SHARED_RAM_ARBITER -- requirements
Module: shared_ram_arbiter

---
 rtl/shared_ram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_shared_ram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_ram_arbiter.sv
// Shares one synchronous 2Kx8 RAM between a 68000 (DTACK handshake) and a Z80
// (WAIT handshake). Simultaneous requests alternate between the two ports.
module shared_ram_arbiter #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned FIRST_GRANT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m68k_req,
  input  logic              m68k_rw,
  input  logic [ADDR_W:1]   m68k_addr,
  input  logic [7:0]        m68k_din,
  output logic [7:0]        m68k_dout,
  output logic              m68k_dtack_n,
  input  logic              z80_req,
  input  logic              z80_wr_n,
  input  logic [ADDR_W-1:0] z80_addr,
  input  logic [7:0]        z80_din,
  output logic [7:0]        z80_dout,
  output logic              z80_wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  localparam int unsigned DATA_W = 8;
  localparam logic GRANT_M = 1'b0;
  localparam logic GRANT_Z = 1'b1;
  // last_grant starts opposite to FIRST_GRANT so the first collision goes to FIRST_GRANT
  localparam logic LAST_GRANT_RST = (FIRST_GRANT == 0) ? GRANT_Z : GRANT_M;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_M  = 3'd1,
    LAT_M  = 3'd2,
    HOLD_M = 3'd3,
    ACC_Z  = 3'd4,
    LAT_Z  = 3'd5,
    HOLD_Z = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_grant;
  logic                w_last_grant;
  logic                r_acc_wr;
  logic                w_acc_wr;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic [DATA_W-1:0]   w_ram_din;
  logic                r_ram_we;
  logic                w_ram_we;
  logic                r_dtack_n;
  logic                w_dtack_n;
  logic [DATA_W-1:0]   r_m68k_dout;
  logic [DATA_W-1:0]   w_m68k_dout;
  logic [DATA_W-1:0]   r_z80_dout;
  logic [DATA_W-1:0]   w_z80_dout;
  logic                w_grant_m;
  logic                w_grant_z;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= LAST_GRANT_RST;
      r_acc_wr     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_ram_we     <= 1'b0;
      r_dtack_n    <= 1'b1;
      r_m68k_dout  <= '0;
      r_z80_dout   <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_last_grant;
      r_acc_wr     <= w_acc_wr;
      r_ram_addr   <= w_ram_addr;
      r_ram_din    <= w_ram_din;
      r_ram_we     <= w_ram_we;
      r_dtack_n    <= w_dtack_n;
      r_m68k_dout  <= w_m68k_dout;
      r_z80_dout   <= w_z80_dout;
    end
  end

  // Next-state and next-output logic; RAM controls are loaded on the grant edge
  always_comb begin
    w_next_state = r_state;
    w_last_grant = r_last_grant;
    w_acc_wr     = r_acc_wr;
    w_ram_addr   = r_ram_addr;
    w_ram_din    = r_ram_din;
    w_ram_we     = 1'b0;
    w_dtack_n    = r_dtack_n;
    w_m68k_dout  = r_m68k_dout;
    w_z80_dout   = r_z80_dout;
    w_grant_m    = 1'b0;
    w_grant_z    = 1'b0;

    case (r_state)
      IDLE: begin
        w_dtack_n = 1'b1;
        if (m68k_req && z80_req) begin
          w_grant_m    = (r_last_grant == GRANT_Z);
          w_grant_z    = (r_last_grant == GRANT_M);
          w_last_grant = ~r_last_grant;
        end else begin
          w_grant_m = m68k_req;
          w_grant_z = z80_req;
        end

        if (w_grant_m) begin
          w_next_state = ACC_M;
          w_ram_addr   = m68k_addr;
          w_ram_din    = m68k_din;
          w_ram_we     = ~m68k_rw;
          w_acc_wr     = ~m68k_rw;
        end else if (w_grant_z) begin
          w_next_state = ACC_Z;
          w_ram_addr   = z80_addr;
          w_ram_din    = z80_din;
          w_ram_we     = ~z80_wr_n;
          w_acc_wr     = ~z80_wr_n;
        end
      end

      ACC_M: w_next_state = LAT_M;

      LAT_M: begin
        if (!r_acc_wr) begin
          w_m68k_dout = ram_dout;
        end
        // an abandoned cycle still completes but never acknowledges
        if (m68k_req) begin
          w_next_state = HOLD_M;
          w_dtack_n    = 1'b0;
        end else begin
          w_next_state = IDLE;
        end
      end

      HOLD_M: begin
        if (!m68k_req) begin
          w_next_state = IDLE;
          w_dtack_n    = 1'b1;
        end
      end

      ACC_Z: w_next_state = LAT_Z;

      LAT_Z: begin
        if (!r_acc_wr) begin
          w_z80_dout = ram_dout;
        end
        w_next_state = z80_req ? HOLD_Z : IDLE;
      end

      HOLD_Z: begin
        if (!z80_req) begin
          w_next_state = IDLE;
        end
      end

      default: begin
        w_next_state = IDLE;
        w_dtack_n    = 1'b1;
      end
    endcase
  end

  assign ram_addr     = r_ram_addr;
  assign ram_din      = r_ram_din;
  assign ram_we       = r_ram_we;
  assign m68k_dout    = r_m68k_dout;
  assign m68k_dtack_n = r_dtack_n;
  assign z80_dout     = r_z80_dout;

  // WAIT is released only in HOLD_Z and is forced inactive while in reset
  assign z80_wait_n = ~(reset_n & z80_req & (r_state != HOLD_Z));

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: directed handshake scenarios followed by randomized
// traffic, checked against a shadow memory and an alternating-priority arbitration model.
module tb_shared_ram_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              m68k_req = 1'b0;
  logic              m68k_rw = 1'b1;
  logic [ADDR_W-1:0] m68k_addr = '0;
  logic [7:0]        m68k_din = '0;
  logic [7:0]        m68k_dout;
  logic              m68k_dtack_n;
  logic              z80_req = 1'b0;
  logic              z80_wr_n = 1'b1;
  logic [ADDR_W-1:0] z80_addr = '0;
  logic [7:0]        z80_din = '0;
  logic [7:0]        z80_dout;
  logic              z80_wait_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [7:0]        ram_dout;

  shared_ram_arbiter #(.ADDR_W(ADDR_W), .FIRST_GRANT(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m68k_req(m68k_req), .m68k_rw(m68k_rw), .m68k_addr(m68k_addr), .m68k_din(m68k_din),
    .m68k_dout(m68k_dout), .m68k_dtack_n(m68k_dtack_n),
    .z80_req(z80_req), .z80_wr_n(z80_wr_n), .z80_addr(z80_addr), .z80_din(z80_din),
    .z80_dout(z80_dout), .z80_wait_n(z80_wait_n),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference state: shadow memory, expected read registers, last collision winner (1 = Z80)
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] exp_mdout;
  logic [7:0] exp_zdout;
  logic       last_z;
  int         n_pass;
  int         n_fail;
  int         n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_drive(input logic rw, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    m68k_rw   = rw;
    m68k_addr = a;
    m68k_din  = d;
    m68k_req  = 1'b1;
  endtask

  task automatic z_drive(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    z80_wr_n = ~wr;
    z80_addr = a;
    z80_din  = d;
    z80_req  = 1'b1;
    #1;
    chk("z_req_wait_low", z80_wait_n, 0);
  endtask

  // 68K cycle from the grant edge; assumes the 68K wins at the next edge
  task automatic m_serve(input logic rw, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                         input int hold_n, input logic abandon);
    tick();
    chk("m_acc_we", ram_we, !rw);
    chk("m_acc_addr", ram_addr, a);
    if (!rw) chk("m_acc_din", ram_din, d);
    chk("m_acc_dtack", m68k_dtack_n, 1);
    if (z80_req) chk("m_acc_zwait", z80_wait_n, 0);
    tick();
    chk("m_lat_we", ram_we, 0);
    chk("m_lat_dtack", m68k_dtack_n, 1);
    if (!rw) ref_mem[a] = d;
    else     exp_mdout  = ref_mem[a];
    if (abandon) begin
      m68k_req = 1'b0;
      tick();
      chk("m_ab_dtack", m68k_dtack_n, 1);
      chk("m_ab_dout", m68k_dout, exp_mdout);
      tick();
      chk("m_ab_dtack2", m68k_dtack_n, 1);
      chk("m_ab_we", ram_we, 0);
    end else begin
      tick();
      chk("m_hold_dtack", m68k_dtack_n, 0);
      chk("m_hold_dout", m68k_dout, exp_mdout);
      for (int i = 0; i < hold_n; i++) begin
        tick();
        chk("m_hold_dtack_kept", m68k_dtack_n, 0);
        chk("m_hold_we", ram_we, 0);
        chk("m_hold_addr", ram_addr, a);
        if (z80_req) chk("m_hold_zwait", z80_wait_n, 0);
      end
      m68k_req = 1'b0;
      tick();
      chk("m_exit_dtack", m68k_dtack_n, 1);
    end
  endtask

  // Z80 cycle from the grant edge; assumes the Z80 wins at the next edge
  task automatic z_serve(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                         input int hold_n);
    tick();
    chk("z_acc_we", ram_we, wr);
    chk("z_acc_addr", ram_addr, a);
    if (wr) chk("z_acc_din", ram_din, d);
    chk("z_acc_wait", z80_wait_n, 0);
    chk("z_acc_dtack", m68k_dtack_n, 1);
    tick();
    chk("z_lat_we", ram_we, 0);
    chk("z_lat_wait", z80_wait_n, 0);
    if (wr) ref_mem[a] = d;
    else    exp_zdout  = ref_mem[a];
    tick();
    chk("z_hold_wait", z80_wait_n, 1);
    chk("z_hold_dout", z80_dout, exp_zdout);
    chk("z_hold_dtack", m68k_dtack_n, 1);
    for (int i = 0; i < hold_n; i++) begin
      tick();
      chk("z_hold_wait_kept", z80_wait_n, 1);
      chk("z_hold_we", ram_we, 0);
    end
    z80_req = 1'b0;
    #1;
    chk("z_drop_wait", z80_wait_n, 1);
    tick();
    chk("z_exit_wait", z80_wait_n, 1);
  endtask

  // Both requests rise together; the winner is the opposite of the previous collision winner
  task automatic collide(input logic mrw, input logic [ADDR_W-1:0] ma, input logic [7:0] md,
                         input logic zwr, input logic [ADDR_W-1:0] za, input logic [7:0] zd,
                         input int hold_n);
    logic win_z;
    m_drive(mrw, ma, md);
    z_drive(zwr, za, zd);
    win_z  = ~last_z;
    last_z = win_z;
    if (win_z) begin
      z_serve(zwr, za, zd, hold_n);
      m_serve(mrw, ma, md, hold_n, 1'b0);
    end else begin
      m_serve(mrw, ma, md, hold_n, 1'b0);
      z_serve(zwr, za, zd, hold_n);
    end
  endtask

  initial begin
    int               kind;
    int               hold_n;
    logic             rw_a;
    logic             rw_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [7:0]       dat_a;
    logic [7:0]       dat_b;

    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[11'h123]     = 8'hA5;
    ref_mem[11'h123] = 8'hA5;
    exp_mdout = 8'h00;
    exp_zdout = 8'h00;
    last_z    = 1'b1;

    // Reset values, with a Z80 request pending to prove WAIT stays inactive
    z80_req = 1'b1;
    #2 reset_n = 1'b0;
    tick();
    chk("rst_dtack", m68k_dtack_n, 1);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_mdout", m68k_dout, 0);
    chk("rst_zdout", z80_dout, 0);
    chk("rst_wait", z80_wait_n, 1);
    z80_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_we", ram_we, 0);

    // 68K read of a preloaded location
    m_drive(1'b1, 11'h123, 8'h00);
    m_serve(1'b1, 11'h123, 8'h00, 2, 1'b0);
    chk("m_read_a5", m68k_dout, 8'hA5);

    // Z80 write at the top address, then 68K reads it back
    z_drive(1'b1, 11'h7FF, 8'h5A);
    z_serve(1'b1, 11'h7FF, 8'h5A, 1);
    m_drive(1'b1, 11'h7FF, 8'h00);
    m_serve(1'b1, 11'h7FF, 8'h00, 0, 1'b0);
    chk("m_read_5a", m68k_dout, 8'h5A);

    // First collision goes to the 68K, the repeat to the Z80
    collide(1'b1, 11'h010, 8'h00, 1'b1, 11'h020, 8'h77, 1);
    collide(1'b0, 11'h030, 8'h99, 1'b1, 11'h040, 8'h00, 1);
    chk("col_data", ref_mem[11'h020], 8'h77);

    // Abandoned 68K read, followed by a normal cycle
    m_drive(1'b1, 11'h020, 8'h00);
    m_serve(1'b1, 11'h020, 8'h00, 0, 1'b1);
    chk("ab_dout", m68k_dout, 8'h77);
    m_drive(1'b0, 11'h050, 8'h3C);
    m_serve(1'b0, 11'h050, 8'h3C, 0, 1'b0);
    chk("wr_keeps_dout", m68k_dout, 8'h77);

    // Reset in the middle of a Z80 write cuts the strobe and the write
    exp_zdout = ref_mem[11'h2AA];
    z_drive(1'b1, 11'h2AA, ~ref_mem[11'h2AA]);
    tick();
    chk("rstw_acc_we", ram_we, 1);
    reset_n = 1'b0;
    #1;
    chk("rstw_we", ram_we, 0);
    chk("rstw_dtack", m68k_dtack_n, 1);
    chk("rstw_addr", ram_addr, 0);
    chk("rstw_din", ram_din, 0);
    chk("rstw_mdout", m68k_dout, 0);
    chk("rstw_zdout", z80_dout, 0);
    chk("rstw_wait", z80_wait_n, 1);
    exp_mdout = 8'h00;
    last_z    = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("rstw_wait_after", z80_wait_n, 0);
    z80_req = 1'b0;
    tick();
    z_drive(1'b0, 11'h2AA, 8'h00);
    z_serve(1'b0, 11'h2AA, 8'h00, 0);
    chk("rstw_no_write", z80_dout, exp_zdout);

    // Back-to-back 68K cycles: one access per request, re-grant after one low edge
    m_drive(1'b0, 11'h060, 8'h11);
    m_serve(1'b0, 11'h060, 8'h11, 4, 1'b0);
    m_drive(1'b1, 11'h060, 8'h00);
    m_serve(1'b1, 11'h060, 8'h00, 1, 1'b0);
    chk("b2b_dout", m68k_dout, 8'h11);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      kind   = int'($urandom_range(0, 4));
      hold_n = int'($urandom_range(0, 3));
      rw_a   = 1'($urandom);
      rw_b   = 1'($urandom);
      addr_a = ADDR_W'($urandom);
      addr_b = ADDR_W'($urandom);
      dat_a  = 8'($urandom);
      dat_b  = 8'($urandom);
      case (kind)
        0: begin
          m_drive(rw_a, addr_a, dat_a);
          m_serve(rw_a, addr_a, dat_a, hold_n, 1'b0);
        end
        1: begin
          z_drive(rw_b, addr_b, dat_b);
          z_serve(rw_b, addr_b, dat_b, hold_n);
        end
        2: collide(rw_a, addr_a, dat_a, rw_b, addr_b, dat_b, hold_n);
        3: begin
          m_drive(rw_a, addr_a, dat_a);
          m_serve(rw_a, addr_a, dat_a, 0, 1'b1);
        end
        default: begin
          m_drive(rw_a, addr_a, dat_a);
          m_serve(rw_a, addr_a, dat_a, hold_n, 1'b0);
          m_drive(1'b1, addr_a, 8'h00);
          m_serve(1'b1, addr_a, 8'h00, 0, 1'b0);
        end
      endcase
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        chk("gap_dtack", m68k_dtack_n, 1);
        chk("gap_we", ram_we, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
